// File: rtl/matu_pkg.sv
// Shared definitions for the MATU feed path: word type and input-buffer slot count.
package matu_pkg;

  // Default operand word width used across the MATU array.
  localparam int unsigned MATU_C_WIDTH = 16;

  // Number of vector slots in the input buffer (ping-pong).
  localparam int unsigned IB_SLOTS = 2;

  // One operand word.
  typedef logic [MATU_C_WIDTH-1:0] matu_word_t;

  // Occupancy update: a load and a slot release in the same cycle cancel out.
  function automatic logic [1:0] count_next(input logic [1:0] cnt,
                                            input logic       inc,
                                            input logic       dec);
    logic [1:0] res;
    res = cnt;
    case ({inc, dec})
      2'b10:   res = cnt + 2'd1;
      2'b01:   res = cnt - 2'd1;
      default: res = cnt;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ib_skew_line.sv
// Depth-N register delay line carrying {valid, data} for one row of the
// input buffer output. Depth 0 degenerates to a wire. o_busy reports any
// valid bit held inside the line so the buffer can report emptiness.
module ib_skew_line #(
  parameter int unsigned DEPTH = 0,
  parameter int unsigned W     = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_busy
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_valid = i_valid;
      assign o_data  = i_data;
      assign o_busy  = 1'b0;
    end else begin : g_line
      logic [DEPTH-1:0]        valid_q;
      logic [DEPTH-1:0]        valid_d;
      logic [DEPTH-1:0][W-1:0] data_q;
      logic [DEPTH-1:0][W-1:0] data_d;

      // Shift the line by one stage every cycle; stage 0 takes the new input.
      always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        valid_d[0] = i_valid;
        data_d[0]  = i_data;
        for (int k = 1; k < int'(DEPTH); k++) begin
          valid_d[k] = valid_q[k-1];
          data_d[k]  = data_q[k-1];
        end
      end

      // Stage registers; reset flushes anything in flight.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          valid_q <= '0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign o_valid = valid_q[DEPTH-1];
      assign o_data  = data_q[DEPTH-1];
      assign o_busy  = |valid_q;
    end
  endgenerate

endmodule

// File: rtl/input_buffer.sv
// Parallel-to-serial staging buffer feeding the MATU array.
// Accepts whole QUEUE_NUM x QUEUE_LEN vectors into two ping-pong slots and
// emits one word per row per controller request, element 0 first.
// Optional macro INPUT_BUFFER_SKEW_EN adds a per-row delay line (row i
// delayed by i cycles) to form the systolic diagonal skew.
module input_buffer
  import matu_pkg::*;
#(
  parameter int unsigned QUEUE_NUM = 1,
  parameter int unsigned QUEUE_LEN = 3,
  parameter int unsigned C_WIDTH   = MATU_C_WIDTH
) (
  input  logic                                              i_clk,
  input  logic                                              i_rst,
  input  logic                                              i_pre_valid,
  output logic                                              o_pre_ready,
  input  logic [QUEUE_NUM-1:0][QUEUE_LEN-1:0][C_WIDTH-1:0]  i_data,
  input  logic                                              i_ctrl_ib_data_out,
  output logic [QUEUE_NUM-1:0][C_WIDTH-1:0]                 o_data,
  output logic [QUEUE_NUM-1:0]                              o_data_valid,
  output logic                                              o_ib_empty,
  output logic                                              o_ib_full
);

  localparam int unsigned IDX_W = (QUEUE_LEN > 1) ? $clog2(QUEUE_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(QUEUE_LEN - 1);
  localparam logic [1:0] COUNT_FULL = 2'(IB_SLOTS);

  typedef logic [QUEUE_NUM-1:0][QUEUE_LEN-1:0][C_WIDTH-1:0] vec_t;

  // Storage and control state.
  vec_t                              slot_q [IB_SLOTS];
  vec_t                              slot_d [IB_SLOTS];
  logic                              wr_ptr_q, wr_ptr_d;
  logic                              rd_ptr_q, rd_ptr_d;
  logic [1:0]                        count_q, count_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [QUEUE_NUM-1:0][C_WIDTH-1:0] data_q, data_d;
  logic                              valid_q, valid_d;

  // Handshake and drain qualifiers.
  logic pre_ready;
  logic pre_fire;
  logic drain;
  logic drain_last;
  logic skew_busy;

  // Ready depends only on registered occupancy, never on the controller.
  always_comb begin
    pre_ready  = (count_q != COUNT_FULL);
    pre_fire   = i_pre_valid & pre_ready;
    drain      = i_ctrl_ib_data_out & (count_q != 2'd0);
    drain_last = drain & (idx_q == IDX_LAST);
  end

  // Next-state: slot writes, pointer/count/index updates and the output word.
  always_comb begin
    slot_d   = slot_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = 1'b0;

    // The write slot is always the free one, so a load never disturbs the
    // slot being drained.
    if (pre_fire) begin
      slot_d[wr_ptr_q] = i_data;
      wr_ptr_d         = ~wr_ptr_q;
    end

    // Drain reads only registered slot contents, so a vector loaded this
    // cycle cannot be emitted until the next one.
    if (drain) begin
      for (int r = 0; r < int'(QUEUE_NUM); r++) begin
        data_d[r] = slot_q[rd_ptr_q][r][idx_q];
      end
      valid_d = 1'b1;
      if (drain_last) begin
        idx_d    = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    count_d = count_next(count_q, pre_fire, drain_last);
  end

  // State registers; reset discards stored vectors and any load/drain this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < int'(IB_SLOTS); s++) begin
        slot_q[s] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      idx_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      slot_q   <= slot_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  end

`ifdef INPUT_BUFFER_SKEW_EN
  logic [QUEUE_NUM-1:0] row_busy;

  // Row gi is delayed by gi extra register stages.
  generate
    for (genvar gi = 0; gi < int'(QUEUE_NUM); gi++) begin : g_skew
      ib_skew_line #(
        .DEPTH (gi),
        .W     (C_WIDTH)
      ) u_skew (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (valid_q),
        .i_data  (data_q[gi]),
        .o_valid (o_data_valid[gi]),
        .o_data  (o_data[gi]),
        .o_busy  (row_busy[gi])
      );
    end
  endgenerate

  assign skew_busy = |row_busy;
`else
  // All rows leave together straight from the output register.
  assign o_data       = data_q;
  assign o_data_valid = {QUEUE_NUM{valid_q}};
  assign skew_busy    = 1'b0;
`endif

  assign o_pre_ready = pre_ready;
  assign o_ib_full   = (count_q == COUNT_FULL);
  assign o_ib_empty  = (count_q == 2'd0) & ~valid_q & ~skew_busy;

endmodule

// File: tb/tb_input_buffer.sv
// Directed bench for input_buffer (QUEUE_NUM=2, QUEUE_LEN=3, C_WIDTH=16)
// with a per-row scoreboard of expected output words.
module tb_input_buffer;

  localparam int QN = 2;
  localparam int QL = 3;
  localparam int CW = 16;

`ifdef INPUT_BUFFER_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif

  logic                          clk;
  logic                          rst;
  logic                          pre_valid;
  logic                          pre_ready;
  logic [QN-1:0][QL-1:0][CW-1:0] data_in;
  logic                          ctrl;
  logic [QN-1:0][CW-1:0]         data_out;
  logic [QN-1:0]                 data_valid;
  logic                          ib_empty;
  logic                          ib_full;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic last_v0 = 1'b0;

  logic [CW-1:0] q_row0 [$];
  logic [CW-1:0] q_row1 [$];

  input_buffer #(
    .QUEUE_NUM (QN),
    .QUEUE_LEN (QL),
    .C_WIDTH   (CW)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_pre_valid        (pre_valid),
    .o_pre_ready        (pre_ready),
    .i_data             (data_in),
    .i_ctrl_ib_data_out (ctrl),
    .o_data             (data_out),
    .o_data_valid       (data_valid),
    .o_ib_empty         (ib_empty),
    .o_ib_full          (ib_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rows: row0 = base..base+2, row1 = base+3..base+5.
  task automatic set_vec(input logic [CW-1:0] base);
    for (int r = 0; r < QN; r++)
      for (int j = 0; j < QL; j++)
        data_in[r][j] = base + CW'(r * QL + j);
  endtask

  task automatic push_vec(input logic [CW-1:0] base);
    for (int j = 0; j < QL; j++) begin
      q_row0.push_back(base + CW'(j));
      q_row1.push_back(base + CW'(QL + j));
    end
  endtask

  // Advance one clock and check per-row valid; row 1 trails row 0 by a cycle
  // when skewed, unless the edge was a reset edge.
  task automatic tick(input logic exp_v0, input logic clr);
    logic exp_v1;
    @(posedge clk);
    #1;
    exp_v1 = SKEW ? (clr ? 1'b0 : last_v0) : exp_v0;
    check("valid_row0", 32'(data_valid[0]), 32'(exp_v0));
    check("valid_row1", 32'(data_valid[1]), 32'(exp_v1));
    last_v0 = exp_v0;
  endtask

  // Scoreboard: every valid output word must be the next expected one for its row.
  always @(negedge clk) begin
    if (data_valid[0]) begin
      if (q_row0.size() == 0) check("sb_extra_row0", 32'(data_valid[0]), 32'd0);
      else check("sb_row0", 32'(data_out[0]), 32'(q_row0.pop_front()));
    end
    if (data_valid[1]) begin
      if (q_row1.size() == 0) check("sb_extra_row1", 32'(data_valid[1]), 32'd0);
      else check("sb_row1", 32'(data_out[1]), 32'(q_row1.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; pre_valid = 1'b0; ctrl = 1'b0; data_in = '0;

    // Reset
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_ready", 32'(pre_ready), 32'd1);
    check("rst_empty", 32'(ib_empty), 32'd1);
    check("rst_full", 32'(ib_full), 32'd0);
    rst = 1'b0;

    // Single vector, first word two cycles after the load edge
    set_vec(16'd1); push_vec(16'd1); pre_valid = 1'b1;
    tick(1'b0, 1'b0);
    check("single_not_empty", 32'(ib_empty), 32'd0);
    pre_valid = 1'b0; ctrl = 1'b1;
    tick(1'b1, 1'b0); check("single_w0", 32'(data_out[0]), 32'd1);
    tick(1'b1, 1'b0); check("single_w1", 32'(data_out[0]), 32'd2);
    tick(1'b1, 1'b0); check("single_w2", 32'(data_out[0]), 32'd3);
    ctrl = 1'b0;
    tick(1'b0, 1'b0);
`ifdef INPUT_BUFFER_SKEW_EN
    check("single_skew_busy", 32'(ib_empty), 32'd0);
    tick(1'b0, 1'b0);
`endif
    check("single_empty", 32'(ib_empty), 32'd1);

    // Back-pressure: third vector refused until a slot frees
    set_vec(16'd10); push_vec(16'd10); pre_valid = 1'b1;
    tick(1'b0, 1'b0);
    check("bp_ready1", 32'(pre_ready), 32'd1);
    check("bp_full1", 32'(ib_full), 32'd0);
    set_vec(16'd20); push_vec(16'd20);
    tick(1'b0, 1'b0);
    check("bp_full2", 32'(ib_full), 32'd1);
    check("bp_ready2", 32'(pre_ready), 32'd0);
    set_vec(16'd30);
    tick(1'b0, 1'b0);
    check("bp_refused_full", 32'(ib_full), 32'd1);
    check("bp_refused_ready", 32'(pre_ready), 32'd0);
    ctrl = 1'b1;
    tick(1'b1, 1'b0); check("bp_a0", 32'(data_out[0]), 32'd10);
    check("bp_a0_ready", 32'(pre_ready), 32'd0);
    tick(1'b1, 1'b0); check("bp_a1_ready", 32'(pre_ready), 32'd0);
    tick(1'b1, 1'b0); check("bp_a2", 32'(data_out[0]), 32'd12);
    check("bp_ready_back", 32'(pre_ready), 32'd1);
    check("bp_not_full", 32'(ib_full), 32'd0);
    push_vec(16'd30);
    tick(1'b1, 1'b0); check("bp_b0_gapless", 32'(data_out[0]), 32'd20);
    check("bp_c_accepted", 32'(ib_full), 32'd1);
    pre_valid = 1'b0;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0); check("bp_b2", 32'(data_out[0]), 32'd22);
    tick(1'b1, 1'b0); check("bp_c0", 32'(data_out[0]), 32'd30);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0); check("bp_c2", 32'(data_out[0]), 32'd32);
    ctrl = 1'b0;
    tick(1'b0, 1'b0);
`ifdef INPUT_BUFFER_SKEW_EN
    tick(1'b0, 1'b0);
`endif
    check("bp_empty", 32'(ib_empty), 32'd1);

    // Controller gaps: 1,0,1,1
    set_vec(16'd40); push_vec(16'd40); pre_valid = 1'b1;
    tick(1'b0, 1'b0);
    pre_valid = 1'b0; ctrl = 1'b1;
    tick(1'b1, 1'b0); check("gap_w0", 32'(data_out[0]), 32'd40);
    ctrl = 1'b0;
    tick(1'b0, 1'b0); check("gap_hold", 32'(data_out[0]), 32'd40);
    ctrl = 1'b1;
    tick(1'b1, 1'b0); check("gap_w1", 32'(data_out[0]), 32'd41);
    tick(1'b1, 1'b0); check("gap_w2", 32'(data_out[0]), 32'd42);
    ctrl = 1'b0;
    tick(1'b0, 1'b0);
`ifdef INPUT_BUFFER_SKEW_EN
    tick(1'b0, 1'b0);
`endif
    check("gap_empty", 32'(ib_empty), 32'd1);

    // Last-element drain coinciding with a load
    set_vec(16'd50); push_vec(16'd50); pre_valid = 1'b1;
    tick(1'b0, 1'b0);
    pre_valid = 1'b0; ctrl = 1'b1;
    tick(1'b1, 1'b0); check("sim_e0", 32'(data_out[0]), 32'd50);
    tick(1'b1, 1'b0);
    set_vec(16'd60); push_vec(16'd60); pre_valid = 1'b1;
    tick(1'b1, 1'b0); check("sim_e2", 32'(data_out[0]), 32'd52);
    check("sim_count1_empty", 32'(ib_empty), 32'd0);
    check("sim_count1_full", 32'(ib_full), 32'd0);
    check("sim_count1_ready", 32'(pre_ready), 32'd1);
    pre_valid = 1'b0;
    tick(1'b1, 1'b0); check("sim_f0_nobubble", 32'(data_out[0]), 32'd60);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0); check("sim_f2", 32'(data_out[0]), 32'd62);
    ctrl = 1'b0;
    tick(1'b0, 1'b0);
`ifdef INPUT_BUFFER_SKEW_EN
    tick(1'b0, 1'b0);
`endif
    check("sim_empty", 32'(ib_empty), 32'd1);

    // Reset after one drain step; load and request in the reset cycle are dropped
    set_vec(16'd70); push_vec(16'd70); pre_valid = 1'b1;
    tick(1'b0, 1'b0);
    pre_valid = 1'b0; ctrl = 1'b1;
    tick(1'b1, 1'b0); check("mrst_w0", 32'(data_out[0]), 32'd70);
    rst = 1'b1; set_vec(16'd80); pre_valid = 1'b1;
    tick(1'b0, 1'b1);
    q_row0.delete();
    q_row1.delete();
    check("mrst_empty", 32'(ib_empty), 32'd1);
    check("mrst_data", 32'(data_out), 32'd0);
    check("mrst_ready", 32'(pre_ready), 32'd1);
    rst = 1'b0; pre_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0);
      check("mrst_stays_empty", 32'(ib_empty), 32'd1);
    end
    ctrl = 1'b0;

    check("sb_left_row0", 32'(q_row0.size()), 32'd0);
    check("sb_left_row1", 32'(q_row1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/input_buffer.md
# input_buffer

Parallel-to-serial staging buffer on the feed side of the MATU array. It accepts a complete `QUEUE_NUM` x `QUEUE_LEN` operand vector from the pre-stage over a valid/ready handshake. It then streams one word per row per cycle into the array whenever the controller asserts `i_ctrl_ib_data_out`. Two vector slots (ping-pong) let the next vector load while the current one drains.

## Interface
- `QUEUE_NUM`, 1, number of rows (parallel output lanes)
- `QUEUE_LEN`, 3, words per row per vector
- `C_WIDTH`, 16, word width
- `i_clk`  in  1  clock; all logic on rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_pre_valid`  in  1  pre-stage vector valid
- `o_pre_ready`  out  1  buffer can accept a vector
- `i_data`  in  `C_WIDTH` x [QUEUE_NUM][QUEUE_LEN]  vector; `[i][j]` = row i, element j
- `i_ctrl_ib_data_out`  in  1  controller request: emit next word on each row
- `o_data`  out  `C_WIDTH` x [QUEUE_NUM]  registered word per row
- `o_data_valid`  out  [QUEUE_NUM]  per-row valid for `o_data`
- `o_ib_empty`  out  1  no stored or in-flight data
- `o_ib_full`  out  1  both slots occupied

## Operation
- State: slots `slot[0..1]`, `wr_ptr`, `rd_ptr` (1 bit each), `count` (0..2), element index `idx` (0..QUEUE_LEN-1).
- `pre_fire = i_pre_valid & o_pre_ready`; `o_pre_ready = (count != 2)`; `o_ib_full = (count == 2)`.
- On `pre_fire`: whole `i_data` written to `slot[wr_ptr]`, `wr_ptr` toggles.
- Drain step when `i_ctrl_ib_data_out & (count != 0)`: `o_data[i] <= slot[rd_ptr][i][idx]`, `o_data_valid <= all ones`, `idx` increments. At `idx == QUEUE_LEN-1`: `idx <= 0`, `rd_ptr` toggles, the slot is freed.
- Element 0 is emitted first, element QUEUE_LEN-1 last.
- No drain step (ctrl low, or count==0): `o_data` holds its last value, `o_data_valid <= 0`, `idx` holds. A request while empty is ignored, not queued.
- `count` next: +1 on `pre_fire` only; -1 on last-element drain only; unchanged when both occur in the same cycle.
- A freshly loaded slot is drainable from the cycle after `pre_fire`. It is never drainable in the same cycle.
- `o_ib_empty = (count == 0)` and no valid bit set in any output or skew register.

## Timing
- Reset values: `o_data` all 0, `o_data_valid` 0, `o_pre_ready` 1, `o_ib_empty` 1, `o_ib_full` 0; pointers, `count`, `idx` 0.
- Reset mid-operation clears all stored and in-flight data at that edge. A `pre_fire` or drain request in the reset cycle is discarded.
- Latency: with `pre_fire` at cycle T and ctrl high from T+1, the first word is visible on `o_data` after edge T+1→T+2, i.e. during T+2.
- Continuous ctrl with back-to-back vectors gives gapless output. The first word of the next slot follows the last word of the current slot on the very next cycle.
- `o_pre_ready` rises in the cycle after the last-element drain of a full buffer. There is no combinational ready-from-ctrl path.

## Configuration
- `INPUT_BUFFER_SKEW_EN` defined: row i output (data and valid) passes through an extra i-stage register delay line. This produces the diagonal systolic skew: row 0 has no extra delay, row QUEUE_NUM-1 lags by QUEUE_NUM-1 cycles. Skew registers reset to 0 and count toward `o_ib_empty`.
- Undefined: no delay lines; all `o_data_valid` bits are identical.

## Structure
- Shared `matu_pkg`: word typedef sized by `C_WIDTH` and constant `IB_SLOTS = 2`.
- One sub-module, `ib_skew_line`: a parameterised depth-N register line of {valid, data}, instantiated per row only under `INPUT_BUFFER_SKEW_EN`. Depth 0 is a pass-through.

## Test plan
All scenarios use QUEUE_NUM=2, QUEUE_LEN=3, C_WIDTH=16.
- Reset check: assert `i_rst` 2 cycles → `o_data`=0, `o_data_valid`=00, `o_pre_ready`=1, `o_ib_empty`=1, `o_ib_full`=0.
- Single vector: load rows {1,2,3}/{4,5,6}, then ctrl held high → `o_data` pairs (1,4),(2,5),(3,6) on 3 consecutive cycles with valid=11, then valid=00 and empty=1.
- Back-pressure: ctrl low, offer 3 vectors → 2 accepted, `o_ib_full`=1 and `o_pre_ready`=0. After 3 drain steps, ready returns the following cycle and the third vector is accepted.
- Ctrl gaps: ctrl pattern 1,0,1,1 on a loaded vector → outputs (1,4), hold with valid=00, (2,5), (3,6).
- Simultaneous events: count=1, last-element drain coincides with `pre_fire` → count stays 1, and the next vector's element 0 is output the following cycle with no bubble.
- Reset mid-drain and skew: reset after 1 drain step → empty next cycle, and old data never reappears. With `INPUT_BUFFER_SKEW_EN`, row 1 words trail row 0 by exactly 1 cycle.
